// File: rtl/rotary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rotary_pkg
// Description : Shared types and constants for the rotary encoder front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rotary_pkg;

    localparam logic [1:0] ROT_REST_AB = 2'b11;
    localparam int         DEBOUNCE_W  = 20;

    typedef enum logic [2:0] {
        REST = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6,
        ERR  = 3'd7
    } rot_state_e;

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Synchroniser chain followed by a stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter
    import rotary_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [DEBOUNCE_W-1:0] c_count_limit = DEBOUNCE_CYCLES[DEBOUNCE_W-1:0];

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEBOUNCE_W-1:0]  r_count;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign dout   = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_level <= RESET_VAL;
        end else if (w_sync == r_level) begin
            r_count <= '0;
        end else if (r_count == c_count_limit) begin
            r_level <= w_sync;
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rotary_decoder
// Description : Debounced quadrature detent decoder with centre-button pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rot_a,
    input  logic rot_b,
    input  logic rot_center,
    output logic rotation_event,
    output logic rotation_dir,
    output logic center_level,
    output logic center_press
);

    logic       w_deb_a;
    logic       w_deb_b;
    logic       w_deb_center;
    logic [1:0] w_ab;

    rot_state_e r_state;
    rot_state_e w_state_next;
    logic       w_event;
    logic       w_dir_next;
    logic       r_event;
    logic       r_dir;
    logic       r_center_prev;
    logic       r_press;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .RESET_VAL       (1'b1)
    ) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rot_a),
        .dout  (w_deb_a)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .RESET_VAL       (1'b1)
    ) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rot_b),
        .dout  (w_deb_b)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .RESET_VAL       (1'b0)
    ) u_deb_center (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rot_center),
        .dout  (w_deb_center)
    );

    assign w_ab = {w_deb_a, w_deb_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= REST;
            r_event       <= 1'b0;
            r_dir         <= 1'b0;
            r_center_prev <= 1'b0;
            r_press       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_event       <= w_event;
            r_dir         <= w_dir_next;
            r_center_prev <= w_deb_center;
            r_press       <= w_deb_center & ~r_center_prev;
        end
    end

    // Unlisted AB codes in each state are "unchanged" and hold the state.
    always_comb begin
        w_state_next = r_state;
        w_event      = 1'b0;
        w_dir_next   = r_dir;
        case (r_state)
            REST: begin
                case (w_ab)
                    2'b01:   w_state_next = CW1;
                    2'b10:   w_state_next = CCW1;
                    2'b00:   w_state_next = ERR;
                    default: w_state_next = REST;
                endcase
            end
            CW1: begin
                case (w_ab)
                    2'b00:       w_state_next = CW2;
                    ROT_REST_AB: w_state_next = REST;
                    2'b10:       w_state_next = ERR;
                    default:     w_state_next = CW1;
                endcase
            end
            CW2: begin
                case (w_ab)
                    2'b10:       w_state_next = CW3;
                    2'b01:       w_state_next = CW1;
                    ROT_REST_AB: w_state_next = ERR;
                    default:     w_state_next = CW2;
                endcase
            end
            CW3: begin
                case (w_ab)
                    ROT_REST_AB: begin
                        w_state_next = REST;
                        w_event      = 1'b1;
                        w_dir_next   = 1'b1;
                    end
                    2'b00:   w_state_next = CW2;
                    2'b01:   w_state_next = ERR;
                    default: w_state_next = CW3;
                endcase
            end
            CCW1: begin
                case (w_ab)
                    2'b00:       w_state_next = CCW2;
                    ROT_REST_AB: w_state_next = REST;
                    2'b01:       w_state_next = ERR;
                    default:     w_state_next = CCW1;
                endcase
            end
            CCW2: begin
                case (w_ab)
                    2'b01:       w_state_next = CCW3;
                    2'b10:       w_state_next = CCW1;
                    ROT_REST_AB: w_state_next = ERR;
                    default:     w_state_next = CCW2;
                endcase
            end
            CCW3: begin
                case (w_ab)
                    ROT_REST_AB: begin
                        w_state_next = REST;
                        w_event      = 1'b1;
                        w_dir_next   = 1'b0;
                    end
                    2'b00:   w_state_next = CCW2;
                    2'b10:   w_state_next = ERR;
                    default: w_state_next = CCW3;
                endcase
            end
            ERR: begin
                if (w_ab == ROT_REST_AB) begin
                    w_state_next = REST;
                end
            end
        endcase
    end

    assign rotation_event = r_event;
    assign rotation_dir   = r_dir;
    assign center_level   = w_deb_center;
    assign center_press   = r_press;

endmodule
`default_nettype wire

// File: tb/tb_rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_decoder
// Description : Randomised and directed bench against a detent-progress model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rotary_decoder;

    localparam int DEB = 4;
    localparam int SYN = 2;
    localparam int HIST = SYN + DEB + 1;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic rot_a      = 1'b1;
    logic rot_b      = 1'b1;
    logic rot_center = 1'b0;
    logic rotation_event;
    logic rotation_dir;
    logic center_level;
    logic center_press;

    always #5 clk = ~clk;

    rotary_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rot_a          (rot_a),
        .rot_b          (rot_b),
        .rot_center     (rot_center),
        .rotation_event (rotation_event),
        .rotation_dir   (rotation_dir),
        .center_level   (center_level),
        .center_press   (center_press)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw sample history, debounced levels, signed detent progress.
    bit hist_a[$];
    bit hist_b[$];
    bit hist_c[$];
    bit m_a, m_b, m_c, m_c_prev;
    int m_pos;
    bit m_err;
    bit [1:0] m_ab_seen;
    bit m_event, m_dir, m_press;
    int cyc = 0;
    int ev_count = 0;
    int press_count = 0;
    int last_ev_cyc = 0;
    bit both_seen = 0;

    function automatic int phase(input bit [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    // A level flips once DEB+1 consecutive samples, lagged by the sync chain, disagree with it.
    function automatic bit settle(input bit q[$], input bit level);
        for (int i = 0; i <= DEB; i++)
            if (q[i] == level) return level;
        return ~level;
    endfunction

    task automatic model_reset();
        m_a = 1; m_b = 1; m_c = 0; m_c_prev = 0;
        m_pos = 0; m_err = 0; m_ab_seen = 2'b11;
        m_event = 0; m_dir = 0; m_press = 0;
        hist_a.delete(); hist_b.delete(); hist_c.delete();
        for (int i = 0; i < HIST; i++) begin
            hist_a.push_back(1'b1);
            hist_b.push_back(1'b1);
            hist_c.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit [1:0] ab;
        int d;
        m_event  = 0;
        m_press  = m_c & ~m_c_prev;
        m_c_prev = m_c;
        ab = {m_a, m_b};
        if (m_err) begin
            if (ab == 2'b11) begin
                m_err = 0;
                m_pos = 0;
            end
        end else if (ab != m_ab_seen) begin
            d = (phase(ab) - phase(m_ab_seen) + 4) % 4;
            if (d == 2) begin
                m_err = 1;
            end else begin
                m_pos += (d == 1) ? 1 : -1;
                if (m_pos == 4) begin
                    m_event = 1; m_dir = 1; m_pos = 0;
                end else if (m_pos == -4) begin
                    m_event = 1; m_dir = 0; m_pos = 0;
                end
            end
        end
        m_ab_seen = ab;
        hist_a.push_back(rot_a); void'(hist_a.pop_front());
        hist_b.push_back(rot_b); void'(hist_b.pop_front());
        hist_c.push_back(rot_center); void'(hist_c.pop_front());
        m_a = settle(hist_a, m_a);
        m_b = settle(hist_b, m_b);
        m_c = settle(hist_c, m_c);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        cyc++;
        #1;
        check_value("event", rotation_event, m_event);
        check_value("dir", rotation_dir, m_dir);
        check_value("level", center_level, m_c);
        check_value("press", center_press, m_press);
        if (rotation_event) begin
            ev_count++;
            last_ev_cyc = cyc;
        end
        if (center_press) press_count++;
        if (rotation_event && center_press) both_seen = 1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic set_ab(input bit [1:0] ab, input int n);
        rot_a = ab[1];
        rot_b = ab[0];
        hold(n);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        check_value("rst_event", rotation_event, 0);
        check_value("rst_dir", rotation_dir, 0);
        check_value("rst_level", center_level, 0);
        check_value("rst_press", center_press, 0);
        tick();
        rst_n = 1;
    endtask

    initial begin
        bit [1:0] gray [4];
        bit [1:0] cur;
        bit [1:0] nxt;
        int sel;
        int start;
        gray[0] = 2'b11; gray[1] = 2'b01; gray[2] = 2'b00; gray[3] = 2'b10;

        model_reset();
        hold(3);
        check_value("init_event", rotation_event, 0);
        check_value("init_dir", rotation_dir, 0);
        check_value("init_level", center_level, 0);
        check_value("init_press", center_press, 0);
        rst_n = 1;
        hold(10);

        // Clockwise detent and its latency from the final edge.
        ev_count = 0;
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b10, 10);
        start = cyc + 1;
        set_ab(2'b11, 10);
        check_value("cw_count", ev_count, 1);
        check_value("cw_dir", rotation_dir, 1);
        check_value("cw_latency", last_ev_cyc - start, 7);

        // Counter-clockwise, then clockwise flips direction back.
        ev_count = 0;
        set_ab(2'b10, 10); set_ab(2'b00, 10); set_ab(2'b01, 10); set_ab(2'b11, 10);
        check_value("ccw_count", ev_count, 1);
        check_value("ccw_dir", rotation_dir, 0);
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b10, 10); set_ab(2'b11, 10);
        check_value("cw2_count", ev_count, 2);
        check_value("cw2_dir", rotation_dir, 1);

        // Bounce on A before it settles low.
        ev_count = 0;
        for (int i = 0; i < 10; i++) begin
            rot_a = ~rot_a;
            hold(2);
        end
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b10, 10); set_ab(2'b11, 10);
        check_value("bounce_count", ev_count, 1);

        // Reversal and two-bit jump give nothing; a clean detent afterwards still works.
        ev_count = 0;
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b01, 10); set_ab(2'b11, 10);
        check_value("reverse_count", ev_count, 0);
        set_ab(2'b01, 10); set_ab(2'b10, 10); set_ab(2'b11, 10);
        check_value("jump_count", ev_count, 0);
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b10, 10); set_ab(2'b11, 10);
        check_value("post_err_count", ev_count, 1);

        // Reset while parked in CW2.
        ev_count = 0;
        set_ab(2'b01, 10); set_ab(2'b00, 10);
        do_reset();
        hold(10);
        set_ab(2'b11, 12);
        check_value("reset_mid_count", ev_count, 0);

        // Bouncy button press and release.
        press_count = 0;
        rot_center = 1; tick();
        rot_center = 0; tick();
        rot_center = 1; hold(15);
        check_value("press_count", press_count, 1);
        check_value("press_level", center_level, 1);
        rot_center = 0; hold(15);
        check_value("release_level", center_level, 0);
        check_value("release_count", press_count, 1);

        // Press coinciding with the detent-completing edge.
        both_seen = 0;
        set_ab(2'b01, 10); set_ab(2'b00, 10); set_ab(2'b10, 10);
        rot_center = 1;
        set_ab(2'b11, 12);
        check_value("coincide", both_seen, 1);
        rot_center = 0;
        hold(10);

        // Random walk with bounces, jumps, button toggles and occasional resets.
        for (int it = 0; it < 200; it++) begin
            sel = $urandom_range(0, 24);
            cur = {rot_a, rot_b};
            if (sel == 0) begin
                do_reset();
            end else begin
                if (sel < 14)      nxt = gray[(phase(cur) + 1) % 4];
                else if (sel < 20) nxt = gray[(phase(cur) + 3) % 4];
                else if (sel < 22) nxt = cur ^ 2'b11;
                else               nxt = cur;
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 4)) begin
                        rot_a = ~rot_a;
                        tick();
                    end
                end
                rot_a = nxt[1];
                rot_b = nxt[0];
                if ($urandom_range(0, 5) == 0) rot_center = ~rot_center;
                hold($urandom_range(1, 12));
            end
        end
        hold(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
